// File: rtl/raymarch_scheduler.sv
// Frame scheduler for a pool of raymarcher cores.
// Walks the frame in raster order handing pixels to idle cores, captures
// each core's result pulse into a per-core slot, and drains the slots
// round-robin onto the single frame-buffer write port.
module raymarch_scheduler #(
  parameter int WIDTH     = 1280,
  parameter int HEIGHT    = 720,
  parameter int NUM_CORES = 4
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  frame_start_in,
  output logic                                  frame_done_out,
  output logic                                  cam_latch_out,
  output logic [31:0]                           frame_count_out,
  output logic [NUM_CORES-1:0]                  core_start_out,
  output logic [$clog2(WIDTH)-1:0]              pix_x_out,
  output logic [$clog2(HEIGHT)-1:0]             pix_y_out,
  input  logic [NUM_CORES-1:0]                  core_done_in,
  input  logic [8*NUM_CORES-1:0]                core_color_in,
  input  logic [$clog2(WIDTH)*NUM_CORES-1:0]    core_x_in,
  input  logic [$clog2(HEIGHT)*NUM_CORES-1:0]   core_y_in,
  output logic                                  fb_we_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]       fb_addr_out,
  output logic [7:0]                            fb_color_out
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = $clog2(WIDTH*HEIGHT);
  localparam int RW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    DISPATCH,
    DRAIN
  } state_t;

  state_t state, next_state;

  logic [XW-1:0]        ptr_x;
  logic [YW-1:0]        ptr_y;
  logic [NUM_CORES-1:0] busy;
  logic [NUM_CORES-1:0] slot_full;
  logic [NUM_CORES-1:0] capture;
  logic [NUM_CORES-1:0] grant_vec;
  logic [7:0]           slot_color [NUM_CORES];
  logic [XW-1:0]        slot_x     [NUM_CORES];
  logic [YW-1:0]        slot_y     [NUM_CORES];
  logic [RW-1:0]        rr_ptr;
  logic [RW-1:0]        grant_idx;
  logic [RW-1:0]        sel_idx;
  logic                 grant_found;
  logic                 sel_found;
  logic                 last_pixel;
  logic                 drain_empty;

  assign capture     = core_done_in & busy;
  assign last_pixel  = (ptr_x == XW'(WIDTH-1)) && (ptr_y == YW'(HEIGHT-1));
  assign drain_empty = (busy == '0) && (slot_full == '0) && !fb_we_out;
  assign pix_x_out   = ptr_x;
  assign pix_y_out   = ptr_y;

  // Pick the lowest-index core that is neither running nor holding a result.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (!busy[i] && !slot_full[i]) begin
        sel_found = 1'b1;
        sel_idx   = RW'(i);
      end
    end
  end

  // Round-robin search over full result slots, starting after the last winner.
  always_comb begin
    logic [RW-1:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = RW'((int'(rr_ptr) + k) % NUM_CORES);
      if (!grant_found && slot_full[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_vec = grant_found ? (NUM_CORES'(1) << grant_idx) : '0;
  end

  // Frame sequencing: next state plus the state-decoded control outputs.
  always_comb begin
    next_state     = state;
    frame_done_out = 1'b0;
    cam_latch_out  = 1'b0;
    core_start_out = '0;
    case (state)
      IDLE: begin
        frame_done_out = 1'b1;
        if (frame_start_in) next_state = LATCH;
      end
      LATCH: begin
        cam_latch_out = 1'b1;
        next_state    = DISPATCH;
      end
      DISPATCH: begin
        if (sel_found) begin
          core_start_out = NUM_CORES'(1) << sel_idx;
          if (last_pixel) next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_empty) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  // Raster-order dispatch pointer, rewound at the start of every frame.
  always_ff @(posedge clk_in) begin
    if (rst_in || state == LATCH) begin
      ptr_x <= '0;
      ptr_y <= '0;
    end else if (core_start_out != '0) begin
      if (ptr_x == XW'(WIDTH-1)) begin
        ptr_x <= '0;
        ptr_y <= (ptr_y == YW'(HEIGHT-1)) ? '0 : ptr_y + 1'b1;
      end else begin
        ptr_x <= ptr_x + 1'b1;
      end
    end
  end

  // Completed-frame counter, bumped only when a frame drains out normally.
  always_ff @(posedge clk_in) begin
    if (rst_in)                                      frame_count_out <= '0;
    else if (state == DRAIN && next_state == IDLE)   frame_count_out <= frame_count_out + 1'b1;
  end

  // Per-core busy and slot-occupancy flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy      <= '0;
      slot_full <= '0;
    end else begin
      busy      <= (busy & ~capture) | core_start_out;
      slot_full <= (slot_full & ~grant_vec) | capture;
    end
  end

  // Result slot payload, loaded whenever a running core reports.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_color[i] <= '0;
        slot_x[i]     <= '0;
        slot_y[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (capture[i]) begin
          slot_color[i] <= core_color_in[8*i +: 8];
          slot_x[i]     <= core_x_in[XW*i +: XW];
          slot_y[i]     <= core_y_in[YW*i +: YW];
        end
      end
    end
  end

  // Registered frame-buffer write of the granted slot.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fb_we_out    <= 1'b0;
      fb_addr_out  <= '0;
      fb_color_out <= '0;
      rr_ptr       <= '0;
    end else begin
      fb_we_out <= grant_found;
      if (grant_found) begin
        fb_addr_out  <= AW'(slot_x[grant_idx]) + AW'(WIDTH) * AW'(slot_y[grant_idx]);
        fb_color_out <= slot_color[grant_idx];
        rr_ptr       <= (grant_idx == RW'(NUM_CORES-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_raymarch_scheduler.sv
// Bench for raymarch_scheduler on a 4x2 frame with two cores.
// A reference model tracks each core as free, running or holding a result
// and predicts starts, pixel order and write contents from those phases.
module tb_raymarch_scheduler;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int N    = 2;
  localparam int XW   = 2;
  localparam int YW   = 1;
  localparam int AW   = 3;
  localparam int NPIX = W*H;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              frame_start_in;
  logic              frame_done_out;
  logic              cam_latch_out;
  logic [31:0]       frame_count_out;
  logic [N-1:0]      core_start_out;
  logic [XW-1:0]     pix_x_out;
  logic [YW-1:0]     pix_y_out;
  logic [N-1:0]      core_done_in;
  logic [8*N-1:0]    core_color_in;
  logic [XW*N-1:0]   core_x_in;
  logic [YW*N-1:0]   core_y_in;
  logic              fb_we_out;
  logic [AW-1:0]     fb_addr_out;
  logic [7:0]        fb_color_out;

  raymarch_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_CORES(N)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .frame_done_out(frame_done_out), .cam_latch_out(cam_latch_out),
    .frame_count_out(frame_count_out), .core_start_out(core_start_out),
    .pix_x_out(pix_x_out), .pix_y_out(pix_y_out),
    .core_done_in(core_done_in), .core_color_in(core_color_in),
    .core_x_in(core_x_in), .core_y_in(core_y_in),
    .fb_we_out(fb_we_out), .fb_addr_out(fb_addr_out), .fb_color_out(fb_color_out)
  );

  // Free-running clock.
  always #5 clk_in = ~clk_in;

  typedef enum int {FREE, RUNNING, PENDING} phase_t;

  typedef struct {
    int min_lat;
    int max_lat;
    bit rand_col;
    bit stray;
    bit extra_start;
    int reset_after;
    int exp_count;
  } frame_vec_t;

  int errors = 0;
  int checks = 0;

  phase_t     phase    [N];
  int         core_pix [N];
  int         core_due [N];
  logic [7:0] core_col [N];
  int         written  [NPIX];
  int         cyc, next_pix, starts, writes, latches;
  bit         dispatching;
  int         min_lat, max_lat;
  bit         rand_col, stray_en;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < N; i++) begin
      phase[i]    = FREE;
      core_pix[i] = -1;
      core_due[i] = 0;
      core_col[i] = 8'h00;
    end
    dispatching = 1'b0;
    next_pix    = 0;
  endtask

  // One clock of the core-pool model: observe the DUT at the falling edge,
  // compare against the model, then drive core results for the next edge.
  task automatic applyStimulus(input bit fs);
    logic [N-1:0] exp_start;
    int           free_core;
    int           owner;
    logic [7:0]   col;
    @(negedge clk_in);
    cyc++;
    if (fb_we_out) begin
      owner = -1;
      for (int i = 0; i < N; i++)
        if (phase[i] == PENDING && core_pix[i] == int'(fb_addr_out)) owner = i;
      checkOutput("write_owner", 64'(owner >= 0), 64'd1);
      if (owner >= 0) begin
        checkOutput("write_color", fb_color_out, core_col[owner]);
        phase[owner] = FREE;
      end
      checkOutput("write_once", written[fb_addr_out], 0);
      written[fb_addr_out]++;
      writes++;
    end
    exp_start = '0;
    free_core = -1;
    if (dispatching && next_pix < NPIX)
      for (int i = N-1; i >= 0; i--)
        if (phase[i] == FREE) free_core = i;
    if (free_core >= 0) exp_start = N'(1) << free_core;
    checkOutput("core_start", core_start_out, exp_start);
    if (free_core >= 0) begin
      checkOutput("pix_x", pix_x_out, next_pix % W);
      checkOutput("pix_y", pix_y_out, next_pix / W);
      phase[free_core]    = RUNNING;
      core_pix[free_core] = next_pix;
      core_due[free_core] = cyc + int'($urandom_range(max_lat, min_lat));
      next_pix++;
      starts++;
    end
    if (cam_latch_out) begin
      latches++;
      dispatching = 1'b1;
      next_pix    = 0;
    end
    core_done_in  = '0;
    core_color_in = '0;
    core_x_in     = '0;
    core_y_in     = '0;
    for (int i = 0; i < N; i++) begin
      if (phase[i] == RUNNING && core_due[i] == cyc) begin
        col = rand_col ? 8'($urandom) : 8'(core_pix[i]);
        core_col[i]              = col;
        core_done_in[i]          = 1'b1;
        core_color_in[8*i +: 8]  = col;
        core_x_in[XW*i +: XW]    = XW'(core_pix[i] % W);
        core_y_in[YW*i +: YW]    = YW'(core_pix[i] / W);
        phase[i]                 = PENDING;
      end else if (stray_en && phase[i] != RUNNING && $urandom_range(3, 0) == 0) begin
        core_done_in[i]          = 1'b1;
        core_color_in[8*i +: 8]  = 8'($urandom);
        core_x_in[XW*i +: XW]    = XW'($urandom);
        core_y_in[YW*i +: YW]    = YW'($urandom);
      end
    end
    frame_start_in = fs;
  endtask

  // Reset in the middle of a frame and confirm everything is back at rest.
  task automatic midFrameReset(input int exp_count);
    @(negedge clk_in);
    rst_in         = 1'b1;
    core_done_in   = '0;
    frame_start_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    checkOutput("rst_frame_done", frame_done_out, 1);
    checkOutput("rst_frame_count", frame_count_out, exp_count);
    checkOutput("rst_fb_we", fb_we_out, 0);
    checkOutput("rst_core_start", core_start_out, 0);
    checkOutput("rst_cam_latch", cam_latch_out, 0);
    checkOutput("rst_fb_addr", fb_addr_out, 0);
    checkOutput("rst_fb_color", fb_color_out, 0);
    @(negedge clk_in);
    checkOutput("rst_no_write", fb_we_out, 0);
    checkOutput("rst_no_start", core_start_out, 0);
    resetModel();
  endtask

  // Run one frame described by a table row and check its totals.
  task automatic runFrame(input frame_vec_t v);
    int budget;
    int nwritten;
    bit extra_done;
    bit fs;
    resetModel();
    for (int a = 0; a < NPIX; a++) written[a] = 0;
    writes   = 0;
    starts   = 0;
    latches  = 0;
    min_lat  = v.min_lat;
    max_lat  = v.max_lat;
    rand_col = v.rand_col;
    stray_en = v.stray;
    applyStimulus(1'b1);
    budget     = 0;
    extra_done = 1'b0;
    while (budget < 400) begin
      fs = v.extra_start && !extra_done && starts >= 2;
      if (fs) extra_done = 1'b1;
      applyStimulus(fs);
      budget++;
      if (v.reset_after > 0 && starts >= v.reset_after) begin
        midFrameReset(v.exp_count);
        return;
      end
      if (latches > 0 && frame_done_out) break;
    end
    checkOutput("frame_finished", 64'(latches > 0 && frame_done_out), 64'd1);
    checkOutput("latch_once", latches, 1);
    checkOutput("start_count", starts, NPIX);
    checkOutput("write_count", writes, NPIX);
    nwritten = 0;
    for (int a = 0; a < NPIX; a++) if (written[a] == 1) nwritten++;
    checkOutput("all_pixels_once", nwritten, NPIX);
    checkOutput("frame_count", frame_count_out, v.exp_count);
    checkOutput("frame_done", frame_done_out, 1);
  endtask

  initial begin
    frame_vec_t vecs [6];
    vecs[0] = '{5, 5, 1'b0, 1'b0, 1'b0, 3, 0};
    vecs[1] = '{5, 5, 1'b0, 1'b0, 1'b0, 0, 1};
    vecs[2] = '{1, 6, 1'b1, 1'b0, 1'b1, 0, 2};
    vecs[3] = '{1, 8, 1'b1, 1'b1, 1'b0, 0, 3};
    vecs[4] = '{1, 3, 1'b1, 1'b1, 1'b1, 0, 4};
    vecs[5] = '{1, 1, 1'b1, 1'b0, 1'b0, 0, 5};

    cyc            = 0;
    rst_in         = 1'b1;
    frame_start_in = 1'b0;
    core_done_in   = '0;
    core_color_in  = '0;
    core_x_in      = '0;
    core_y_in      = '0;
    resetModel();

    // Reset held for two cycles.
    repeat (2) @(negedge clk_in);
    checkOutput("reset_frame_done", frame_done_out, 1);
    checkOutput("reset_frame_count", frame_count_out, 0);
    checkOutput("reset_fb_we", fb_we_out, 0);
    checkOutput("reset_core_start", core_start_out, 0);
    checkOutput("reset_cam_latch", cam_latch_out, 0);
    rst_in = 1'b0;

    // Stray result pulse from a core that was never started.
    core_done_in  = 2'b10;
    core_x_in     = {2'd3, 2'd0};
    core_color_in = {8'h55, 8'h00};
    @(negedge clk_in);
    core_done_in = '0;
    checkOutput("stray_no_write0", fb_we_out, 0);
    checkOutput("stray_idle", frame_done_out, 1);
    @(negedge clk_in);
    checkOutput("stray_no_write1", fb_we_out, 0);
    checkOutput("stray_no_start", core_start_out, 0);
    checkOutput("stray_count", frame_count_out, 0);

    // Both cores report in the same cycle; both results must be written.
    frame_start_in = 1'b1;
    @(negedge clk_in);
    frame_start_in = 1'b0;
    checkOutput("sim_latch", cam_latch_out, 1);
    checkOutput("sim_not_done", frame_done_out, 0);
    @(negedge clk_in);
    checkOutput("sim_start0", core_start_out, 2'b01);
    checkOutput("sim_start0_x", pix_x_out, 0);
    checkOutput("sim_latch_gone", cam_latch_out, 0);
    @(negedge clk_in);
    checkOutput("sim_start1", core_start_out, 2'b10);
    checkOutput("sim_start1_x", pix_x_out, 1);
    @(negedge clk_in);
    checkOutput("sim_pool_full", core_start_out, 0);
    core_done_in  = 2'b11;
    core_x_in     = {2'd2, 2'd1};
    core_y_in     = 2'b00;
    core_color_in = {8'hBB, 8'hAA};
    @(negedge clk_in);
    core_done_in = '0;
    checkOutput("sim_min_latency", fb_we_out, 0);
    @(negedge clk_in);
    checkOutput("sim_we0", fb_we_out, 1);
    checkOutput("sim_addr0", fb_addr_out, 1);
    checkOutput("sim_color0", fb_color_out, 8'hAA);
    @(negedge clk_in);
    checkOutput("sim_we1", fb_we_out, 1);
    checkOutput("sim_addr1", fb_addr_out, 2);
    checkOutput("sim_color1", fb_color_out, 8'hBB);
    midFrameReset(0);

    // Table of whole frames, including an aborted one.
    for (int r = 0; r < 6; r++) runFrame(vecs[r]);

    repeat (3) begin
      @(negedge clk_in);
      checkOutput("idle_no_write", fb_we_out, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence wedges.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
